display_scan_ctrl: RTL and testbench

//   Upstream driver for the 4-digit multiplexed 7-segment display.
//   - Divides clk down to a digit-refresh tick and steps a 2-bit digit index sel; sel feeds the digit-select demux.
//   - Produces the matching active-low segment pattern for the selected hex nibble, with optional leading-zero blanking.
//   - New display values are buffered and committed only at frame boundaries, so digits never tear mid-frame.

---
 rtl/display_pkg.sv | 16 +
 rtl/hex_to_seg.sv | 11 +
 rtl/display_scan_ctrl.sv | 80 ++++++++
 tb/tb_display_scan_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
// Segment codes are {g,f,e,d,c,b,a}, active-low.
package display_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam int         SEL_W      = 2;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller: prescaled digit stepping,
// frame-aligned commit of buffered values, leading-zero blanking, registered segments.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [15:0]      data_in,
    input  logic [3:0]       dp_mask,
    output logic [SEL_W-1:0] sel,
    output logic [6:0]       seg_n,
    output logic             dp_n,
    output logic             busy,
    output logic             frame_done
);

    logic [CNT_W-1:0]      cnt;
    logic [15:0]           disp;
    logic [15:0]           pending;
    logic                  tick;
    logic                  boundary;
    logic [3:0]            nibble;
    logic [6:0]            dec_seg;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic                  blank;

    assign tick     = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign boundary = tick && (sel == SEL_W'(NUM_DIGITS - 1));
    assign nibble   = disp[{sel, 2'b00} +: 4];

    hex_to_seg u_dec (
        .nibble (nibble),
        .seg_n  (dec_seg)
    );

    // upper_zero[i]: digit i and every digit above it are zero
    always_comb begin
        upper_zero = '0;
        upper_zero[NUM_DIGITS-1] = (disp[4*(NUM_DIGITS-1) +: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (disp[4*i +: 4] == 4'h0);
        end
    end

    // digit 0 always lights so an all-zero value still reads "0"
    assign blank = BLANK_LZ && (sel != '0) && upper_zero[sel];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            sel        <= '0;
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            disp       <= '0;
            pending    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + 1'b1;
            frame_done <= boundary;
            if (tick) sel <= sel + 1'b1;
            // commit sees the pre-edge pending, so a coincident write lands a frame later
            if (boundary && busy) disp <= pending;
            if (wr_en) begin
                pending <= data_in;
                busy    <= 1'b1;
            end else if (boundary) begin
                busy    <= 1'b0;
            end
            seg_n <= blank ? SEG_BLANK : dec_seg;
            dp_n  <= ~dp_mask[sel];
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with REFRESH_DIV=4: cycle-level model,
// table-driven frame vectors, boundary/reset sequences and randomized traffic.
module tb_display_scan_ctrl;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] data_in;
    logic [3:0]  dp_mask;
    logic [1:0]  sel;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        busy;
    logic        frame_done;

    display_scan_ctrl #(.REFRESH_DIV(DIV), .CNT_W(4), .BLANK_LZ(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .dp_mask    (dp_mask),
        .sel        (sel),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [6:0] pat [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // reference model: time since reset release plus the display registers
    int          m_n    = 0;
    logic [15:0] m_disp = 0;
    logic [15:0] m_pend = 0;
    logic        m_busy = 0;
    logic        m_fd   = 0;
    logic [6:0]  m_seg  = 7'h7F;
    logic        m_dp   = 1;
    logic [3:0]  cur_mask = 4'h0;
    logic [6:0]  got_seg [4];
    logic        busy_seen;

    typedef struct {
        logic [15:0] data;
        logic [6:0]  exp [4];
    } vec_t;
    vec_t vt [5];

    function automatic logic [6:0] exp_seg(logic [15:0] v, int d);
        logic [15:0] upper;
        upper = v >> (4 * d);
        if (d != 0 && upper == 0) return 7'h7F;
        return pat[upper & 16'hF];
    endfunction

    task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // one clock: drive inputs, advance model, compare all outputs
    task automatic cyc(logic wr, logic [15:0] d, logic r);
        int  s;
        logic bnd;
        rst_n   = r;
        wr_en   = wr;
        data_in = d;
        dp_mask = cur_mask;
        @(posedge clk);
        if (!r) begin
            m_n = 0; m_disp = 0; m_pend = 0; m_busy = 0; m_fd = 0;
            m_seg = 7'h7F; m_dp = 1;
        end else begin
            s     = (m_n / DIV) % 4;
            bnd   = (m_n % FRAME) == FRAME - 1;
            m_seg = exp_seg(m_disp, s);
            m_dp  = ~cur_mask[s];
            if (bnd && m_busy) m_disp = m_pend;
            if (wr) begin
                m_pend = d;
                m_busy = 1;
            end else if (bnd) begin
                m_busy = 0;
            end
            m_fd = bnd;
            m_n++;
        end
        #1;
        chk("sel",        16'(sel),        16'((m_n / DIV) % 4));
        chk("seg_n",      16'(seg_n),      16'(m_seg));
        chk("dp_n",       16'(dp_n),       16'(m_dp));
        chk("busy",       16'(busy),       16'(m_busy));
        chk("frame_done", 16'(frame_done), 16'(m_fd));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b1);
    endtask

    task automatic align_frame();
        while (m_n % FRAME != 0) cyc(1'b0, 16'h0, 1'b1);
    endtask

    // run one full frame from its start, recording seg_n per digit as the output register presents it
    task automatic grab_frame();
        busy_seen = 0;
        align_frame();
        for (int i = 0; i < FRAME; i++) begin
            cyc(1'b0, 16'h0, 1'b1);
            got_seg[((m_n - 1) / DIV) % 4] = seg_n;
            busy_seen |= busy;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 3 * FRAME) begin
            cyc(1'b0, 16'h0, 1'b1);
            k++;
        end
        chk("busy_timeout", 16'(busy), 16'h0);
    endtask

    initial begin
        vt[0] = '{16'h12AF, '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001}};
        vt[1] = '{16'h0008, '{7'b0000000, 7'h7F, 7'h7F, 7'h7F}};
        vt[2] = '{16'h0000, '{7'b1000000, 7'h7F, 7'h7F, 7'h7F}};
        vt[3] = '{16'h0F00, '{7'b1000000, 7'b1000000, 7'b0001110, 7'h7F}};
        vt[4] = '{16'h8421, '{7'b1111001, 7'b0100100, 7'b0011001, 7'b0000000}};

        // reset held for three edges
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b0);
        chk("rst_seg", 16'(seg_n), 16'h7F);
        chk("rst_sel", 16'(sel), 16'h0);

        // free-running scan: frame_done once per frame, sel stepping every DIV
        begin
            int fd_cnt = 0;
            for (int i = 0; i < 2 * FRAME; i++) begin
                cyc(1'b0, 16'h0, 1'b1);
                fd_cnt += int'(frame_done);
                if (i == DIV - 1) chk("first_tick_sel", 16'(sel), 16'h1);
            end
            chk("fd_per_frame", 16'(fd_cnt), 16'h2);
        end

        // mid-frame write keeps old value until boundary, then table frames
        for (int v = 0; v < 5; v++) begin
            align_frame();
            idle(5);
            cyc(1'b1, vt[v].data, 1'b1);
            chk("busy_after_wr", 16'(busy), 16'h1);
            wait_idle();
            grab_frame();
            for (int d = 0; d < 4; d++) chk($sformatf("vec%0d_dig%0d", v, d), 16'(got_seg[d]), 16'(vt[v].exp[d]));
        end

        // write coincident with boundary while 2222 is pending
        align_frame();
        idle(2);
        cyc(1'b1, 16'h2222, 1'b1);
        while (m_n % FRAME != FRAME - 1) cyc(1'b0, 16'h0, 1'b1);
        cyc(1'b1, 16'h1111, 1'b1);
        chk("bnd_fd", 16'(frame_done), 16'h1);
        chk("bnd_busy", 16'(busy), 16'h1);
        grab_frame();
        chk("bnd_frame1_d0", 16'(got_seg[0]), 16'(7'b0100100));
        chk("bnd_frame1_d3", 16'(got_seg[3]), 16'(7'b0100100));
        chk("bnd_frame1_busy", 16'(busy_seen), 16'h1);
        grab_frame();
        chk("bnd_frame2_d0", 16'(got_seg[0]), 16'(7'b1111001));
        chk("bnd_frame2_d3", 16'(got_seg[3]), 16'(7'b1111001));
        chk("bnd_frame2_busy", 16'(busy), 16'h0);

        // decimal point on digit 2 only
        cur_mask = 4'b0100;
        align_frame();
        for (int i = 0; i < FRAME; i++) begin
            cyc(1'b0, 16'h0, 1'b1);
            chk("dp_digit2", 16'(dp_n), 16'(((m_n - 1) / DIV) % 4 != 2));
        end

        // reset mid-frame discards pending
        idle(6);
        cyc(1'b1, 16'hBEEF, 1'b1);
        idle(1);
        cyc(1'b0, 16'h0, 1'b0);
        chk("midrst_sel", 16'(sel), 16'h0);
        chk("midrst_seg", 16'(seg_n), 16'h7F);
        chk("midrst_dp", 16'(dp_n), 16'h1);
        chk("midrst_busy", 16'(busy), 16'h0);
        grab_frame();
        chk("midrst_disp_d0", 16'(got_seg[0]), 16'(7'b1000000));
        chk("midrst_disp_d1", 16'(got_seg[1]), 16'h7F);

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            logic        wr;
            logic [15:0] d;
            logic        r;
            wr = ($urandom_range(0, 7) == 0);
            d  = 16'($urandom) & {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
                                 {4{$urandom_range(0, 1) == 1}}, 4'hF};
            r  = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 15) == 0) cur_mask = 4'($urandom);
            cyc(wr, d, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
